// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined lane-reduction tree feeding a frame accumulator, with ready/valid flow control.
// Define ADDER_TREE_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping modulo 2^ACC_W.
module adder_tree_acc #(
  parameter int DATAWIDTH           = 4,
  parameter int NUM_INPUTS          = 16,
  parameter int NUM_PIPELINE_STAGES = 1,
  parameter bit SIGNED              = 1'b0,
  parameter int ACC_W               = DATAWIDTH + $clog2(NUM_INPUTS) + 8,
  parameter int CNT_W               = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_valid,
  output logic                                 i_ready,
  input  logic                                 i_last,
  input  logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] in_data,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic [ACC_W-1:0]                     o_sum,
  output logic [CNT_W-1:0]                     o_count,
  output logic                                 o_ovf
);

  localparam int LEVELS = $clog2(NUM_INPUTS);
  localparam int TREE_W = DATAWIDTH + LEVELS;

  function automatic int entries(input int lvl);
    int n;
    n = NUM_INPUTS;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  logic adv;
  assign adv     = ~o_valid | o_ready;
  assign i_ready = adv;

  // Boundary b holds the entries of tree level b; each boundary is either a register or a wire.
  for (genvar b = 0; b <= LEVELS; b++) begin : g_bnd
    localparam int N = entries(b);
    localparam int W = DATAWIDTH + b;

    logic [N*W-1:0] pre_d;
    logic [N*W-1:0] post_d;
    logic           pre_v;
    logic           pre_l;
    logic           post_v;
    logic           post_l;

    if (b == 0) begin : g_in
      assign pre_d = in_data;
      assign pre_v = i_valid;
      assign pre_l = i_last;
    end else begin : g_add
      localparam int NP = entries(b - 1);
      localparam int WP = W - 1;

      for (genvar j = 0; j < N; j++) begin : g_node
        logic [WP-1:0] lo;
        assign lo = g_bnd[b-1].post_d[(2*j)*WP +: WP];

        if (2 * j + 1 < NP) begin : g_pair
          logic [WP-1:0] hi;
          assign hi = g_bnd[b-1].post_d[(2*j+1)*WP +: WP];
          assign pre_d[j*W +: W] = {SIGNED & lo[WP-1], lo} + {SIGNED & hi[WP-1], hi};
        end else begin : g_pass
          assign pre_d[j*W +: W] = {SIGNED & lo[WP-1], lo};
        end
      end

      assign pre_v = g_bnd[b-1].post_v;
      assign pre_l = g_bnd[b-1].post_l;
    end

    if (b < NUM_PIPELINE_STAGES) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          post_d <= '0;
          post_v <= 1'b0;
          post_l <= 1'b0;
        end else if (adv) begin
          post_d <= pre_d;
          post_v <= pre_v;
          post_l <= pre_l;
        end
      end
    end else begin : g_wire
      assign post_d = pre_d;
      assign post_v = pre_v;
      assign post_l = pre_l;
    end
  end

  logic [TREE_W-1:0] tree_sum;
  logic              t_valid;
  logic              t_last;
  assign tree_sum = g_bnd[LEVELS].post_d;
  assign t_valid  = g_bnd[LEVELS].post_v;
  assign t_last   = g_bnd[LEVELS].post_l;

  logic             first;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] tree_ext;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_raw;
  logic [ACC_W-1:0] acc_n;
  logic             carry;
  logic             ovf_now;
  logic             ovf_n;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_n;

  // A frame's first beat ignores whatever the accumulator state holds from the previous frame.
  always_comb begin
    tree_ext = ACC_W'(tree_sum);
    if (SIGNED) tree_ext = ACC_W'($signed(tree_sum));
    acc_base = first ? '0 : acc;
    {carry, acc_raw} = {1'b0, acc_base} + {1'b0, tree_ext};
    ovf_now = carry;
    if (SIGNED)
      ovf_now = (acc_base[ACC_W-1] == tree_ext[ACC_W-1]) && (acc_raw[ACC_W-1] != acc_base[ACC_W-1]);
    acc_n = acc_raw;
`ifdef ADDER_TREE_ACC_SAT_EN
    if (ovf_now) begin
      if (!SIGNED)                acc_n = '1;
      else if (acc_base[ACC_W-1]) acc_n = {1'b1, {(ACC_W-1){1'b0}}};
      else                        acc_n = {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    ovf_n    = (~first & ovf) | ovf_now;
    cnt_base = first ? '0 : cnt;
    cnt_n    = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  // adv with o_valid set implies o_ready, so dropping o_valid here is always a consumed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_count <= '0;
      o_ovf   <= 1'b0;
      first   <= 1'b1;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else if (adv) begin
      o_valid <= 1'b0;
      if (t_valid) begin
        if (t_last) begin
          o_sum   <= acc_n;
          o_count <= cnt_n;
          o_ovf   <= ovf_n;
          o_valid <= 1'b1;
          first   <= 1'b1;
        end else begin
          acc   <= acc_n;
          cnt   <= cnt_n;
          ovf   <= ovf_n;
          first <= 1'b0;
        end
      end
    end
  end

endmodule
